seg_p2s_tx: RTL
===============

Name: seg_p2s_tx

Overview:
- Parallel-to-serial transmitter that drives the on-board 7-segment shift-register chain.
- Takes the 64-bit segment map produced by the display-mapping logic and shifts it out MSB-first on a divided serial clock.
- Pulses the output-latch enable once all bits are shifted; reports busy/done to the display controller.
- Sits between the segment-map combinational stage and the board's serial display pins.

Parameters:
- DATA_W, 64, number of bits per frame (segment map width).
- CLK_DIV, 2, clk cycles per s_clk half-period; legal range 1..255.
- REFRESH_CYC, 1024, idle clk cycles between automatic frames (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  DATA_W  segment map to transmit; sampled only on an accepted start.
- start  input  1  request one frame; level-sampled in IDLE.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when the frame is complete.
- s_clk  output  1  serial shift clock to the display chain.
- s_data  output  1  serial data, valid around the s_clk rising edge.
- s_clrn  output  1  active-low clear of the external shift chain.
- s_en  output  1  output-latch enable pulse.

Behaviour:
- Reset values, applied asynchronously while rst_n=0:
  - busy=0, done=0, s_clk=0, s_data=0, s_clrn=0, s_en=0.
  - Shift register cleared, counters cleared, state=IDLE.
- Reset behaviour:
  - s_clrn rises to 1 on the first clk edge after rst_n deasserts and stays 1 thereafter.
  - Reset mid-frame aborts the frame immediately. No done pulse is issued. The external chain is cleared through s_clrn.
- States: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE:
  - If start=1 at a rising edge, data is captured into the internal shift register on that edge and state goes to SHIFT.
  - busy=1 from the next cycle.
- SHIFT:
  - Each bit occupies 2*CLK_DIV cycles: CLK_DIV cycles with s_clk=0, then CLK_DIV cycles with s_clk=1.
  - s_data is updated only at the start of a low phase, so it is stable across the rising edge.
  - Bit order: data[DATA_W-1] first, data[0] last.
  - A bit counter runs 0..DATA_W-1. After the high phase of the last bit, s_clk returns to 0 and state goes to LATCH.
- LATCH:
  - s_en=1 for exactly CLK_DIV cycles; s_clk=0 and s_data=0 throughout.
  - Then state goes to IDLE with done=1 for one cycle and busy=0 in that same cycle.
- Start handling:
  - start while busy=1 is ignored; there is no queueing.
  - start asserted in the done cycle is accepted (state is already IDLE), giving back-to-back frames with no gap cycle.
- data may change freely during a frame; only the captured copy is shifted.
- Frame length in clk cycles = DATA_W*2*CLK_DIV + CLK_DIV, from the first busy cycle to the last s_en cycle.
- Counters are sized to hold DATA_W-1 and CLK_DIV-1 without wrap. The bit counter never wraps within a frame.

Optional Feature:
- Macro: SEG_AUTO_REFRESH_EN.
- Defined:
  - An idle counter increments every cycle in IDLE and clears on any frame start.
  - When it reaches REFRESH_CYC-1 with start=0, a frame starts automatically using the current data, exactly as if start had been asserted.
  - Explicit start still takes effect immediately.
- Not defined:
  - Frames start only on start.
  - The idle counter and REFRESH_CYC logic are absent.

Test Plan:
1. Reset and basic frame timing:
   - Stimulus: rst_n=0 for 3 cycles, then release; DATA_W=64, CLK_DIV=2; start=1 at cycle 0 with data=64'h8000_0000_0000_0001.
   - Outputs show reset values during reset, and s_clrn=1 after the first edge post-release.
   - busy=1 for cycles 1..258.
   - s_clk rising at cycles 3+4i.
   - s_data=1 for bit 0 and bit 63 only.
   - s_en=1 at cycles 257..258; done=1 and busy=0 at cycle 259.
2. Bit order:
   - data=64'hA5A5_0000_FFFF_1234 with a bench shift-register model.
   - Reconstructed 64-bit word equals data exactly.
3. start while busy and data mutation:
   - Pulse start and change data at cycle 100 of a frame.
   - No restart, the frame shifts the original word, exactly one done pulse.
4. Back-to-back frames:
   - Hold start=1 continuously.
   - The second frame's busy begins at the cycle after done, and each frame is 258 busy cycles with one done pulse.
5. Reset mid-frame:
   - Drop rst_n at cycle 50 of a frame.
   - busy, s_clk, s_en go to 0 and s_clrn to 0 immediately; no done pulse.
   - After release, a new start gives a correct frame.
6. SEG_AUTO_REFRESH_EN defined, REFRESH_CYC=16, start=0:
   - Frames start every 16 idle cycles with current data, and done pulses periodically.
   - With the macro undefined, no frame ever starts.

Source files
------------

// File: rtl/seg_p2s_tx.sv
// seg_p2s_tx: serialises a segment map MSB-first onto the display shift chain.
// Optional SEG_AUTO_REFRESH_EN: start a frame after REFRESH_CYC idle cycles.
module seg_p2s_tx #(
    parameter int DATA_W      = 64,
    parameter int CLK_DIV     = 2,
    parameter int REFRESH_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              s_data,
    output logic              s_clrn,
    output logic              s_en
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-2:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              go;
    logic              div_end;
    logic              bit_last;

    assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_last = (bit_cnt == BIT_W'(DATA_W - 1));

`ifdef SEG_AUTO_REFRESH_EN
    localparam int IDLE_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    logic [IDLE_W-1:0] idle_cnt;

    assign go = start || (idle_cnt == IDLE_W'(REFRESH_CYC - 1));

    // Idle timer: counts IDLE cycles, restarts whenever a frame begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state == IDLE) begin
            if (go) idle_cnt <= '0;
            else    idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign go = start;
`endif

    // Frame sequencer: capture, shift each bit over 2*CLK_DIV cycles, latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_clk   <= 1'b0;
            s_data  <= 1'b0;
            s_clrn  <= 1'b0;
            s_en    <= 1'b0;
        end else begin
            s_clrn <= 1'b1;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state   <= SHIFT;
                        shreg   <= data[DATA_W-2:0];
                        s_data  <= data[DATA_W-1];
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        s_clk   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!s_clk) begin
                            s_clk <= 1'b1;
                        end else begin
                            s_clk <= 1'b0;
                            if (bit_last) begin
                                state  <= LATCH;
                                s_en   <= 1'b1;
                                s_data <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                s_data  <= shreg[DATA_W-2];
                                shreg   <= {shreg[DATA_W-3:0], 1'b0};
                            end
                        end
                    end
                end
                LATCH: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        s_en    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
